// File: rtl/riscv_pkg.sv
// Shared load/store size codes and LSU state encoding.
package riscv_pkg;
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} lsu_state_t;
endpackage

// File: rtl/riscv_lsu_if.sv
// Core-side and memory-side signals of the load-store unit.
// The slave modport is the LSU's view; master is the core+memory environment.
interface riscv_lsu_if #(parameter int ADDR_W = 32);
    logic              core_req_i;
    logic              core_we_i;
    logic [2:0]        core_size_i;
    logic [ADDR_W-1:0] core_addr_i;
    logic [31:0]       core_wd_i;
    logic [31:0]       core_rd_o;
    logic              core_stall_o;
    logic              err_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [3:0]        mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wd_o;
    logic [31:0]       mem_rd_i;
    logic              mem_ready_i;

    modport slave (
        input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
               mem_rd_i, mem_ready_i,
        output core_rd_o, core_stall_o, err_o,
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );
    modport master (
        output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
               mem_rd_i, mem_ready_i,
        input  core_rd_o, core_stall_o, err_o,
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );
endinterface

// File: rtl/riscv_lsu_data_align.sv
// Combinational lane logic: byte enables, store replication, load
// extraction/extension and the misaligned/illegal-size check.
module lsu_data_align
    import riscv_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] mem_rd_i,
    output logic [3:0]  be_o,
    output logic [31:0] wd_o,
    output logic [31:0] rd_o,
    output logic        bad_o
);
    logic [31:0] shifted;

    always_comb begin
        shifted = mem_rd_i >> {addr_lo_i, 3'b000};
        be_o    = 4'b0000;
        wd_o    = wd_i;
        rd_o    = 32'd0;
        bad_o   = 1'b0;
        case (size_i)
            LDST_B, LDST_BU: begin
                be_o = 4'b0001 << addr_lo_i;
                wd_o = {4{wd_i[7:0]}};
                rd_o = {{24{shifted[7] & (size_i == LDST_B)}}, shifted[7:0]};
            end
            LDST_H, LDST_HU: begin
                be_o  = 4'b0011 << addr_lo_i;
                wd_o  = {2{wd_i[15:0]}};
                rd_o  = {{16{shifted[15] & (size_i == LDST_H)}}, shifted[15:0]};
                bad_o = addr_lo_i[0];
            end
            LDST_W: begin
                be_o  = 4'b1111;
                rd_o  = mem_rd_i;
                bad_o = |addr_lo_i;
            end
            default: bad_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: handshake-driven variable stall between core and data
// memory, with sized accesses, timeout and error reporting.
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    riscv_lsu_if.slave  bus
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] rd_q, rd_d;
    logic        err_q, err_d;
    logic        req, stall, mem_req;
    logic [3:0]  al_be;
    logic [31:0] al_wd, al_rd, cap_rd;
    logic        al_bad;

    lsu_data_align u_align (
        .size_i   (bus.core_size_i),
        .addr_lo_i(bus.core_addr_i[1:0]),
        .wd_i     (bus.core_wd_i),
        .mem_rd_i (bus.mem_rd_i),
        .be_o     (al_be),
        .wd_o     (al_wd),
        .rd_o     (al_rd),
        .bad_o    (al_bad)
    );

    assign cap_rd = bus.core_we_i ? 32'd0 : al_rd;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        err_d   = err_q;
        req     = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: if (bus.core_req_i) begin
                stall = 1'b1;
                if (al_bad) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rd_d    = 32'd0;
                end else begin
                    req = 1'b1;
                    if (bus.mem_ready_i) begin
                        state_d = DONE;
                        err_d   = 1'b0;
                        rd_d    = cap_rd;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(1);
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                req   = 1'b1;
                // Ready takes priority over a timeout landing on the same cycle.
                if (bus.mem_ready_i) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    rd_d    = cap_rd;
                end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rd_d    = 32'd0;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // Gated by rst_i so the memory request drops as soon as reset asserts.
    assign mem_req          = req & ~rst_i;
    assign bus.mem_req_o    = mem_req;
    assign bus.core_stall_o = stall & ~rst_i;
    assign bus.mem_we_o     = mem_req & bus.core_we_i;
    assign bus.mem_be_o     = mem_req ? al_be : 4'b0000;
    assign bus.mem_addr_o   = mem_req ? {bus.core_addr_i[ADDR_W-1:2], 2'b00} : '0;
    assign bus.mem_wd_o     = mem_req ? al_wd : 32'd0;
    assign bus.core_rd_o    = (state_q == DONE && !rst_i) ? rd_q : 32'd0;
    assign bus.err_o        = (state_q == DONE) & err_q & ~rst_i;
endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized and directed checks of riscv_lsu against a byte-lane reference model.
module tb_riscv_lsu;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    riscv_lsu_if #(.ADDR_W(32)) bus ();

    riscv_lsu #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stall;
        int          reqc;
        logic        err;
        logic [31:0] rd;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] addr;
        logic        we;
        bit          hung;
    } obs_t;

    // Reference: treats the word as four byte lanes and an access as n lanes at offset.
    function automatic obs_t model(input logic we, input logic [2:0] sz,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] mrd, input int dly);
        obs_t e;
        int n, off;
        bit sg, bad;
        logic [63:0] v;
        e = '{default: 0};
        off = int'(a[1:0]);
        sg = 0; bad = 0; n = 1;
        case (sz)
            3'd0: begin n = 1; sg = 1; end
            3'd1: begin n = 2; sg = 1; end
            3'd2: n = 4;
            3'd4: n = 1;
            3'd5: n = 2;
            default: bad = 1;
        endcase
        if (!bad && (off % n) != 0) bad = 1;
        e.addr = a & ~32'h3;
        e.we = we;
        for (int i = 0; i < 4; i++) begin
            e.be[i] = (i >= off) && (i < off + n);
            e.wd[8*i +: 8] = wd[8*(i % n) +: 8];
        end
        if (bad) begin
            e.stall = 1; e.err = 1; e.rd = 0; e.reqc = 0;
        end else begin
            if (dly <= TO) begin
                e.stall = dly + 1; e.err = 0;
                v = 64'd0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mrd[8*(off+i) +: 8];
                if (sg && v[8*n-1]) v = v | (~64'd0 << (8*n));
                e.rd = we ? 32'd0 : v[31:0];
            end else begin
                e.stall = TO + 1; e.err = 1; e.rd = 0;
            end
            e.reqc = e.stall;
        end
        return e;
    endfunction

    // dly = request-relative cycle in which mem_ready_i is raised (0 = same cycle).
    task automatic drive_txn(input logic we, input logic [2:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] mrd,
                             input int dly, output obs_t o);
        int k;
        o = '{default: 0};
        bus.core_req_i = 1'b1; bus.core_we_i = we; bus.core_size_i = sz;
        bus.core_addr_i = a; bus.core_wd_i = wd; bus.mem_rd_i = mrd;
        bus.mem_ready_i = (dly == 0);
        k = 0;
        forever begin
            @(negedge clk);
            if (!bus.core_stall_o) begin
                o.err = bus.err_o; o.rd = bus.core_rd_o;
                break;
            end
            o.stall++;
            if (bus.mem_req_o) begin
                if (o.reqc == 0) begin
                    o.be = bus.mem_be_o; o.wd = bus.mem_wd_o;
                    o.addr = bus.mem_addr_o; o.we = bus.mem_we_o;
                end
                o.reqc++;
            end
            if (o.stall > 20) begin o.hung = 1; break; end
            @(posedge clk); #1;
            k++;
            bus.mem_ready_i = (k == dly);
        end
    endtask

    task automatic go_idle();
        bus.core_req_i = 1'b0; bus.mem_ready_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.core_req_i = 1'b1; bus.core_we_i = 1'b0; bus.core_size_i = 3'd2;
        bus.core_addr_i = 32'h100; bus.core_wd_i = 32'h0;
        bus.mem_rd_i = 32'h0; bus.mem_ready_i = 1'b1;
        @(negedge clk);
        n_chk++; if ({bus.mem_req_o, bus.core_stall_o, bus.err_o, bus.core_rd_o} !== 35'd0)
            $display("FAIL reset_outs got req=%b stall=%b err=%b rd=%h want all 0",
                     bus.mem_req_o, bus.core_stall_o, bus.err_o, bus.core_rd_o); else n_pass++;
        bus.core_req_i = 1'b0; bus.mem_ready_i = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_chk++; if ({bus.mem_req_o, bus.core_stall_o, bus.err_o, bus.mem_be_o} !== 7'd0)
            $display("FAIL idle_outs got req=%b stall=%b err=%b be=%b want 0",
                     bus.mem_req_o, bus.core_stall_o, bus.err_o, bus.mem_be_o); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        obs_t o;
        drive_txn(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, o);
        n_chk++; if (o.stall !== 1 || o.rd !== 32'hDEADBEEF || o.err !== 1'b0 || o.be !== 4'b1111)
            $display("FAIL lw_fast got stall=%0d rd=%h err=%b be=%b want 1 deadbeef 0 1111",
                     o.stall, o.rd, o.err, o.be); else n_pass++;
        go_idle();
        drive_txn(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF0000, 3, o);
        n_chk++; if (o.stall !== 4 || o.rd !== 32'hFFFFFF80 || o.err !== 1'b0)
            $display("FAIL lb_wait got stall=%0d rd=%h err=%b want 4 ffffff80 0",
                     o.stall, o.rd, o.err); else n_pass++;
        go_idle();
        drive_txn(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF0000, 3, o);
        n_chk++; if (o.stall !== 4 || o.rd !== 32'h00000080)
            $display("FAIL lbu_wait got stall=%0d rd=%h want 4 00000080", o.stall, o.rd); else n_pass++;
        go_idle();
        drive_txn(1'b1, 3'd1, 32'h102, 32'h1234ABCD, 32'h55555555, 0, o);
        n_chk++; if (o.addr !== 32'h100 || o.be !== 4'b1100 || o.wd !== 32'hABCDABCD || o.we !== 1'b1 || o.rd !== 32'd0)
            $display("FAIL sh got addr=%h be=%b wd=%h we=%b rd=%h want 100 1100 abcdabcd 1 0",
                     o.addr, o.be, o.wd, o.we, o.rd); else n_pass++;
        go_idle();
        drive_txn(1'b0, 3'd2, 32'h101, 32'h0, 32'hFFFFFFFF, 0, o);
        n_chk++; if (o.reqc !== 0 || o.stall !== 1 || o.err !== 1'b1 || o.rd !== 32'd0)
            $display("FAIL lw_misalign got reqc=%0d stall=%0d err=%b rd=%h want 0 1 1 0",
                     o.reqc, o.stall, o.err, o.rd); else n_pass++;
        go_idle();
        drive_txn(1'b0, 3'd3, 32'h100, 32'h0, 32'hFFFFFFFF, 0, o);
        n_chk++; if (o.reqc !== 0 || o.stall !== 1 || o.err !== 1'b1 || o.rd !== 32'd0)
            $display("FAIL size3 got reqc=%0d stall=%0d err=%b rd=%h want 0 1 1 0",
                     o.reqc, o.stall, o.err, o.rd); else n_pass++;
        go_idle();
        drive_txn(1'b0, 3'd2, 32'h200, 32'h0, 32'h12345678, 99, o);
        n_chk++; if (o.stall !== TO + 1 || o.err !== 1'b1 || o.rd !== 32'd0)
            $display("FAIL timeout got stall=%0d err=%b rd=%h want %0d 1 0",
                     o.stall, o.err, o.rd, TO + 1); else n_pass++;
        go_idle();
        drive_txn(1'b0, 3'd2, 32'h200, 32'h0, 32'h12345678, TO, o);
        n_chk++; if (o.stall !== TO + 1 || o.err !== 1'b0 || o.rd !== 32'h12345678)
            $display("FAIL ready_at_limit got stall=%0d err=%b rd=%h want %0d 0 12345678",
                     o.stall, o.err, o.rd, TO + 1); else n_pass++;
        go_idle();
    endtask

    task automatic test_random();
        obs_t o, e;
        logic we;
        logic [2:0] sz;
        logic [31:0] a, wd, mrd;
        int dly;
        for (int t = 0; t < 40; t++) begin
            we = 1'($urandom_range(0, 1)); sz = 3'($urandom_range(0, 7));
            a = $urandom; wd = $urandom; mrd = $urandom; dly = $urandom_range(0, TO + 2);
            e = model(we, sz, a, wd, mrd, dly);
            drive_txn(we, sz, a, wd, mrd, dly, o);
            n_chk++; if (o.hung || o.stall !== e.stall || o.reqc !== e.reqc || o.err !== e.err || o.rd !== e.rd)
                $display("FAIL rnd%0d_resp got stall=%0d reqc=%0d err=%b rd=%h want %0d %0d %b %h",
                         t, o.stall, o.reqc, o.err, o.rd, e.stall, e.reqc, e.err, e.rd); else n_pass++;
            if (e.reqc > 0) begin
                n_chk++; if (o.be !== e.be || o.addr !== e.addr || o.we !== e.we || (we && o.wd !== e.wd))
                    $display("FAIL rnd%0d_bus got be=%b addr=%h we=%b wd=%h want %b %h %b %h",
                             t, o.be, o.addr, o.we, o.wd, e.be, e.addr, e.we, e.wd); else n_pass++;
            end
            if (o.hung) go_idle();
            else if ($urandom_range(0, 1) == 0) go_idle();
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        logic [31:0] mrd;
        for (int t = 0; t < 4; t++) begin
            mrd = $urandom;
            e = model(1'b0, 3'd5, 32'h300 + 32'(2 * t), 32'h0, mrd, t);
            drive_txn(1'b0, 3'd5, 32'h300 + 32'(2 * t), 32'h0, mrd, t, o);
            n_chk++; if (o.stall !== e.stall || o.rd !== e.rd || o.err !== e.err)
                $display("FAIL b2b%0d got stall=%0d rd=%h err=%b want %0d %h %b",
                         t, o.stall, o.rd, o.err, e.stall, e.rd, e.err); else n_pass++;
        end
        go_idle();
    endtask

    task automatic test_reset_mid_wait();
        obs_t o;
        bus.core_req_i = 1'b1; bus.core_we_i = 1'b0; bus.core_size_i = 3'd2;
        bus.core_addr_i = 32'h400; bus.mem_rd_i = 32'hCAFEF00D; bus.mem_ready_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        n_chk++; if (bus.mem_req_o !== 1'b1 || bus.core_stall_o !== 1'b1)
            $display("FAIL wait_active got req=%b stall=%b want 1 1", bus.mem_req_o, bus.core_stall_o); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_chk++; if (bus.mem_req_o !== 1'b0 || bus.core_stall_o !== 1'b0)
            $display("FAIL async_rst got req=%b stall=%b want 0 0", bus.mem_req_o, bus.core_stall_o); else n_pass++;
        @(posedge clk); #1;
        bus.core_req_i = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.err_o !== 1'b0 || bus.core_stall_o !== 1'b0 || bus.core_rd_o !== 32'd0)
            $display("FAIL post_rst got err=%b stall=%b rd=%h want 0 0 0",
                     bus.err_o, bus.core_stall_o, bus.core_rd_o); else n_pass++;
        @(posedge clk); #1;
        drive_txn(1'b0, 3'd2, 32'h404, 32'h0, 32'h0BADC0DE, 1, o);
        n_chk++; if (o.stall !== 2 || o.rd !== 32'h0BADC0DE || o.err !== 1'b0)
            $display("FAIL post_rst_lw got stall=%0d rd=%h err=%b want 2 0badc0de 0",
                     o.stall, o.rd, o.err); else n_pass++;
        go_idle();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
